// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared register-address constants and width helper
// Purpose: common localparams for destination-register pipelines plus a
//          constant clog2 used to size select and forward-index fields.
// Ports:   none (package).
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// rtl/dest_stage_reg.sv - one pipeline stage holding {valid, address}
// Purpose: W-bit register with asynchronous active-low clear; loads d when
//          load is high, otherwise holds.
// Ports:   clk, rst_n (async clear), load (enable), d (next value), q (state).
module dest_stage_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dest_reg_sel_pipe.sv
// rtl/dest_reg_sel_pipe.sv - destination-register selector with hazard pipeline
// Purpose: selects the write address from NUM_IN candidates, carries it with its
//          valid flag through DEPTH stages, and compares two source addresses
//          against all in-flight destinations.
// Ports:   clk, rst_n (async, active-low); in_addr/sel/in_valid (candidate pick);
//          stall/flush (pipeline control); src_a/src_b (sources to check);
//          stage_addr/stage_valid (per-stage state, stage 0 youngest);
//          out_addr/out_valid (writeback stage); hit_a/hit_b (per-stage match);
//          fwd_a_idx/fwd_b_idx (youngest hit, DEPTH = none); sel_err (bad select).
module dest_reg_sel_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH         = REG_ADDR_W,
  parameter int NUM_IN        = 3,
  parameter int SEL_W         = clog2(NUM_IN),
  parameter int DEPTH         = 3,
  parameter int IDX_W         = clog2(DEPTH + 1),
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_addr,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        src_a,
  input  logic [WIDTH-1:0]        src_b,
  output logic [DEPTH*WIDTH-1:0]  stage_addr,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [WIDTH-1:0]        out_addr,
  output logic                    out_valid,
  output logic [DEPTH-1:0]        hit_a,
  output logic [DEPTH-1:0]        hit_b,
  output logic [IDX_W-1:0]        fwd_a_idx,
  output logic [IDX_W-1:0]        fwd_b_idx,
  output logic                    sel_err
);

  logic             sel_ok;
  logic [WIDTH-1:0] mux_addr;
  logic             entry_valid;
  logic [WIDTH:0]   stage_q [DEPTH];
  logic [WIDTH:0]   stage_d [DEPTH];
  logic [DEPTH-1:0] stage_ld;

  // Candidate selection; an out-of-range select yields address 0, never valid.
  always_comb begin
    sel_ok   = (int'(sel) < NUM_IN);
    mux_addr = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) mux_addr = in_addr[k*WIDTH +: WIDTH];
    end
    entry_valid = in_valid && sel_ok &&
                  !(ZERO_SUPPRESS && (mux_addr == WIDTH'(ZERO_REG)));
  end

  // Stage 0 also loads during stall+flush, but only to drop its valid bit
  // while keeping the address.
  always_comb begin
    stage_ld    = '0;
    stage_d[0]  = '0;
    stage_ld[0] = !stall || flush;
    if (stall) begin
      stage_d[0] = {1'b0, stage_q[0][WIDTH-1:0]};
    end else if (!flush) begin
      stage_d[0] = {entry_valid, mux_addr};
    end
    for (int i = 1; i < DEPTH; i++) begin
      stage_ld[i] = !stall;
      stage_d[i]  = stage_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dest_stage_reg #(.W(WIDTH + 1)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (stage_ld[g]),
      .d     (stage_d[g]),
      .q     (stage_q[g])
    );
    assign stage_addr[g*WIDTH +: WIDTH] = stage_q[g][WIDTH-1:0];
    assign stage_valid[g]               = stage_q[g][WIDTH];
  end

  assign out_addr  = stage_q[DEPTH-1][WIDTH-1:0];
  assign out_valid = stage_q[DEPTH-1][WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (!stall) begin
      sel_err <= !sel_ok && in_valid && !flush;
    end else if (flush) begin
      sel_err <= 1'b0;
    end
  end

  // Hit compare and youngest-first priority encode (lowest index wins).
  always_comb begin
    hit_a     = '0;
    hit_b     = '0;
    fwd_a_idx = IDX_W'(DEPTH);
    fwd_b_idx = IDX_W'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      hit_a[i] = stage_q[i][WIDTH] && (stage_q[i][WIDTH-1:0] == src_a) &&
                 !(ZERO_SUPPRESS && (src_a == WIDTH'(ZERO_REG)));
      hit_b[i] = stage_q[i][WIDTH] && (stage_q[i][WIDTH-1:0] == src_b) &&
                 !(ZERO_SUPPRESS && (src_b == WIDTH'(ZERO_REG)));
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_a[i]) fwd_a_idx = IDX_W'(i);
      if (hit_b[i]) fwd_b_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_dest_reg_sel_pipe.sv
// tb/tb_dest_reg_sel_pipe.sv - self-checking bench for dest_reg_sel_pipe
module tb_dest_reg_sel_pipe;
  localparam int W = 5;
  localparam int N = 3;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_addr;
  logic [1:0]     sel;
  logic           in_valid, stall, flush;
  logic [W-1:0]   src_a, src_b;
  logic [D*W-1:0] stage_addr;
  logic [D-1:0]   stage_valid, hit_a, hit_b;
  logic [W-1:0]   out_addr;
  logic           out_valid, sel_err;
  logic [1:0]     fwd_a_idx, fwd_b_idx;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 is the youngest instruction.
  int m_addr [D];
  bit m_valid [D];
  bit m_err;

  dest_reg_sel_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
    .stage_addr(stage_addr), .stage_valid(stage_valid), .out_addr(out_addr),
    .out_valid(out_valid), .hit_a(hit_a), .hit_b(hit_b),
    .fwd_a_idx(fwd_a_idx), .fwd_b_idx(fwd_b_idx), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_addr[i] = 0;
      m_valid[i] = 0;
    end
    m_err = 0;
  endtask

  // Register-file view: a source depends on an in-flight write when some valid
  // stage targets the same register, and register 0 never counts.
  function automatic logic [D-1:0] ref_hits(input int src);
    logic [D-1:0] h;
    h = '0;
    for (int i = 0; i < D; i++) h[i] = m_valid[i] && (m_addr[i] == src) && (src != 0);
    return h;
  endfunction

  function automatic int ref_idx(input logic [D-1:0] h);
    for (int i = 0; i < D; i++) if (h[i]) return i;
    return D;
  endfunction

  task automatic check_all();
    logic [D*W-1:0] ea;
    logic [D-1:0]   ev;
    for (int i = 0; i < D; i++) begin
      ea[i*W +: W] = W'(m_addr[i]);
      ev[i] = m_valid[i];
    end
    chk("stage_addr", 32'(stage_addr), 32'(ea));
    chk("stage_valid", 32'(stage_valid), 32'(ev));
    chk("out_addr", 32'(out_addr), 32'(m_addr[D-1]));
    chk("out_valid", 32'(out_valid), 32'(m_valid[D-1]));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("hit_a", 32'(hit_a), 32'(ref_hits(int'(src_a))));
    chk("hit_b", 32'(hit_b), 32'(ref_hits(int'(src_b))));
    chk("fwd_a_idx", 32'(fwd_a_idx), 32'(ref_idx(ref_hits(int'(src_a)))));
    chk("fwd_b_idx", 32'(fwd_b_idx), 32'(ref_idx(ref_hits(int'(src_b)))));
  endtask

  // One clock: update the reference from the inputs present at the edge,
  // then compare 1 time unit later.
  task automatic step();
    int  a;
    bit  v;
    @(posedge clk);
    a = (int'(sel) < N) ? int'(in_addr[int'(sel)*W +: W]) : 0;
    v = in_valid && (int'(sel) < N) && (a != 0);
    if (!stall) begin
      for (int i = D - 1; i > 0; i--) begin
        m_addr[i]  = m_addr[i-1];
        m_valid[i] = m_valid[i-1];
      end
      m_addr[0]  = flush ? 0 : a;
      m_valid[0] = flush ? 0 : v;
      m_err      = (int'(sel) >= N) && in_valid && !flush;
    end else if (flush) begin
      m_valid[0] = 0;
      m_err      = 0;
    end
    #1;
    check_all();
  endtask

  task automatic load(input int a);
    in_addr = {5'd31, 5'd12, W'(a)};
    sel = 2'd0;
    in_valid = 1'b1;
    step();
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_addr = '0; sel = '0; in_valid = 0; stall = 0; flush = 0;
    src_a = '0; src_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Pick channel 1 and follow it to writeback.
    in_addr = {5'd31, 5'd12, 5'd8}; sel = 2'd1; in_valid = 1'b1;
    step();
    chk("load_stage0", 32'(stage_addr[W-1:0]), 32'd12);
    bubble();
    bubble();
    chk("wb_addr", 32'(out_addr), 32'd12);
    chk("wb_valid", 32'(out_valid), 32'd1);

    // Back-to-back writes to the same register: youngest wins.
    load(7);
    load(7);
    in_valid = 1'b0; src_a = 5'd7; #1 check_all();
    chk("dup_hit", 32'(hit_a), 32'b011);
    chk("dup_idx", 32'(fwd_a_idx), 32'd0);
    bubble();
    bubble();
    chk("old_hit", 32'(hit_a), 32'b100);
    chk("old_idx", 32'(fwd_a_idx), 32'd2);

    // Register 0 is never valid and never hits.
    load(0);
    chk("zero_valid", 32'(stage_valid[0]), 32'd0);
    src_a = 5'd0; #1 check_all();
    chk("zero_hit", 32'(hit_a), 32'd0);
    chk("zero_idx", 32'(fwd_a_idx), 32'd3);

    // Out-of-range select.
    sel = 2'd3; in_valid = 1'b1;
    step();
    chk("bad_sel_valid", 32'(stage_valid[0]), 32'd0);
    chk("bad_sel_err", 32'(sel_err), 32'd1);

    // Stall holds, stall+flush kills only stage 0.
    load(4); load(9); load(5);
    in_valid = 1'b1; in_addr = {5'd31, 5'd12, 5'd3}; sel = 2'd0; stall = 1'b1;
    step();
    step();
    chk("stall_addr", 32'(stage_addr), 32'({5'd4, 5'd9, 5'd5}));
    flush = 1'b1;
    step();
    chk("stall_flush_valid", 32'(stage_valid), 32'b110);
    chk("stall_flush_addr", 32'(stage_addr), 32'({5'd4, 5'd9, 5'd5}));
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between edges.
    load(6); load(17); load(22);
    @(negedge clk);
    chk("pre_reset_valid", 32'(stage_valid), 32'b111);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_addr", 32'(stage_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      in_addr  = {W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7))};
      sel      = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 4) == 0);
      src_a    = W'($urandom_range(0, 7));
      src_b    = W'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
